// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: configurable width, mode (CPOL/CPHA) and bit order,
// with valid/ready RX/TX handshakes, a one-word TX holding buffer and error pulses.
module spi_slave_param #(
  parameter int               DATA_W    = 8,
  parameter bit               CPOL      = 1'b0,
  parameter bit               CPHA      = 1'b0,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [DATA_W-1:0] IDLE_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              ssel_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int             CW   = $clog2(DATA_W);
  localparam logic [CW-1:0]  LAST = CW'(DATA_W - 1);

  // Handshakes: a transfer happens on any clk edge where valid && ready are both
  // high; valid holds its data stable until that edge, ready may change freely.

  logic [2:0]        sck_sr;
  logic [2:0]        ssel_sr;
  logic [1:0]        mosi_sr;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] tx_buf;
  logic              buf_full;

  logic selected;
  logic ssel_fall;
  logic ssel_rise;
  logic sck_rise;
  logic sck_fall;
  logic lead_edge;
  logic trail_edge;
  logic sample_edge;
  logic shift_edge;
  logic word_done;
  logic load;
  logic capture;

  // Index 1 is the synchronised level, index 2 the delayed copy for edge detection.
  assign selected    = ~ssel_sr[1];
  assign ssel_fall   = ~ssel_sr[1] & ssel_sr[2];
  assign ssel_rise   = ssel_sr[1] & ~ssel_sr[2];
  assign sck_rise    = sck_sr[1] & ~sck_sr[2];
  assign sck_fall    = ~sck_sr[1] & sck_sr[2];
  assign lead_edge   = CPOL ? sck_fall : sck_rise;
  assign trail_edge  = CPOL ? sck_rise : sck_fall;
  assign sample_edge = selected & (CPHA ? trail_edge : lead_edge);
  assign shift_edge  = selected & (CPHA ? lead_edge : trail_edge);
  assign word_done   = sample_edge && (bit_cnt == LAST);
  assign load        = (ssel_fall && !CPHA) || (shift_edge && (bit_cnt == '0));
  assign capture     = tx_valid && !buf_full;

  assign rx_next  = MSB_FIRST ? {rx_shift[DATA_W-2:0], mosi_sr[1]}
                              : {mosi_sr[1], rx_shift[DATA_W-1:1]};
  assign busy     = selected;
  assign miso_oe  = selected;
  assign miso     = selected & (MSB_FIRST ? tx_shift[DATA_W-1] : tx_shift[0]);
  assign tx_ready = ~buf_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_sr      <= {3{CPOL}};
      ssel_sr     <= 3'b111;
      mosi_sr     <= '0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_shift    <= '0;
      tx_buf      <= '0;
      buf_full    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      sck_sr      <= {sck_sr[1:0], sck};
      ssel_sr     <= {ssel_sr[1:0], ssel_n};
      mosi_sr     <= {mosi_sr[0], mosi};
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;

      if (ssel_rise) begin
        bit_cnt <= '0;
      end else if (sample_edge) begin
        bit_cnt  <= (bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);
        rx_shift <= rx_next;
      end

      // A completing word wins over the consumer's acceptance of the old one.
      if (word_done && (!rx_valid || rx_ready)) begin
        rx_data  <= rx_next;
        rx_valid <= 1'b1;
      end else begin
        if (word_done) rx_overrun <= 1'b1;
        if (rx_ready)  rx_valid   <= 1'b0;
      end

      if (load) begin
        tx_shift <= buf_full ? tx_buf : IDLE_WORD;
        if (!buf_full) tx_underrun <= 1'b1;
      end else if (shift_edge) begin
        tx_shift <= MSB_FIRST ? (tx_shift << 1) : (tx_shift >> 1);
      end

      // A load with an empty buffer takes IDLE_WORD, so a same-cycle capture stays buffered.
      if (load)    buf_full <= 1'b0;
      if (capture) begin
        tx_buf   <= tx_data;
        buf_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: three instances (8b mode 0 MSB, 16b mode 3 LSB,
// 8b mode 1 with IDLE_WORD 0x5A) driven by a bit-banged SPI master.
module tb_spi_slave_param;

  localparam int HALF = 60;

  logic        clk;
  logic        rst_n;
  logic [2:0]  sck;
  logic [2:0]  ssel_n;
  logic [2:0]  mosi;
  logic [2:0]  tx_valid;
  logic [2:0]  rx_ready;
  wire  [2:0]  miso;
  wire  [2:0]  miso_oe;
  wire  [2:0]  tx_ready;
  wire  [2:0]  rx_valid;
  wire  [2:0]  rx_overrun;
  wire  [2:0]  tx_underrun;
  wire  [2:0]  busy;
  logic [7:0]  tx_data_a;
  logic [15:0] tx_data_b;
  logic [7:0]  tx_data_c;
  wire  [7:0]  rx_data_a;
  wire  [15:0] rx_data_b;
  wire  [7:0]  rx_data_c;

  int dw   [3] = '{8, 16, 8};
  bit cpol [3] = '{1'b0, 1'b1, 1'b0};
  bit cpha [3] = '{1'b0, 1'b1, 1'b1};
  bit msbf [3] = '{1'b1, 1'b0, 1'b1};

  logic [31:0] exp_q_a[$];
  logic [31:0] exp_q_b[$];
  logic [31:0] exp_q_c[$];
  logic [31:0] exp_miso_q[$];
  int n_cmp;
  int n_fail;
  int ov_cnt  [3];
  int und_cnt [3];

  spi_slave_param #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .IDLE_WORD(8'h00)) u_a (
    .clk(clk), .rst_n(rst_n), .sck(sck[0]), .ssel_n(ssel_n[0]), .mosi(mosi[0]),
    .miso(miso[0]), .miso_oe(miso_oe[0]), .tx_data(tx_data_a), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .rx_data(rx_data_a), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
    .rx_overrun(rx_overrun[0]), .tx_underrun(tx_underrun[0]), .busy(busy[0]));

  spi_slave_param #(.DATA_W(16), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0), .IDLE_WORD(16'h0000)) u_b (
    .clk(clk), .rst_n(rst_n), .sck(sck[1]), .ssel_n(ssel_n[1]), .mosi(mosi[1]),
    .miso(miso[1]), .miso_oe(miso_oe[1]), .tx_data(tx_data_b), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .rx_data(rx_data_b), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
    .rx_overrun(rx_overrun[1]), .tx_underrun(tx_underrun[1]), .busy(busy[1]));

  spi_slave_param #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b1), .IDLE_WORD(8'h5A)) u_c (
    .clk(clk), .rst_n(rst_n), .sck(sck[2]), .ssel_n(ssel_n[2]), .mosi(mosi[2]),
    .miso(miso[2]), .miso_oe(miso_oe[2]), .tx_data(tx_data_c), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .rx_data(rx_data_c), .rx_valid(rx_valid[2]), .rx_ready(rx_ready[2]),
    .rx_overrun(rx_overrun[2]), .tx_underrun(tx_underrun[2]), .busy(busy[2]));

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops on every rx handshake and counts error pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (rx_overrun[d])  ov_cnt[d]++;
        if (tx_underrun[d]) und_cnt[d]++;
      end
      if (rx_valid[0] && rx_ready[0]) begin
        if (exp_q_a.size() == 0) check("rx_a_unexpected", {24'h0, rx_data_a}, 32'hFFFF_FFFF);
        else check("rx_a", {24'h0, rx_data_a}, exp_q_a.pop_front());
      end
      if (rx_valid[1] && rx_ready[1]) begin
        if (exp_q_b.size() == 0) check("rx_b_unexpected", {16'h0, rx_data_b}, 32'hFFFF_FFFF);
        else check("rx_b", {16'h0, rx_data_b}, exp_q_b.pop_front());
      end
      if (rx_valid[2] && rx_ready[2]) begin
        if (exp_q_c.size() == 0) check("rx_c_unexpected", {24'h0, rx_data_c}, 32'hFFFF_FFFF);
        else check("rx_c", {24'h0, rx_data_c}, exp_q_c.pop_front());
      end
    end
  end

  // Driver: TX holding-buffer push with bounded wait on tx_ready
  task automatic tx_push(input int d, input logic [31:0] v);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx_ready[d]) begin
        tx_valid[d] = 1'b1;
        case (d)
          0:       tx_data_a = v[7:0];
          1:       tx_data_b = v[15:0];
          default: tx_data_c = v[7:0];
        endcase
        @(posedge clk);
        #1;
        tx_valid[d] = 1'b0;
        return;
      end
    end
    check("tx_push_timeout", 32'd0, 32'd1);
  endtask

  // Driver: SPI master frame of nw words; abort_at >= 0 deselects after that many bits.
  task automatic spi_frame(input int d, input int nw, input logic [31:0] w0,
                           input logic [31:0] w1, input int abort_at);
    logic [31:0] w;
    logic [31:0] got;
    int bi;
    int nbit;
    nbit = 0;
    ssel_n[d] = 1'b0;
    #(2 * HALF);
    for (int wi = 0; wi < nw; wi++) begin
      w   = (wi == 0) ? w0 : w1;
      got = '0;
      for (int b = 0; b < dw[d]; b++) begin
        if (nbit == abort_at) begin
          #HALF;
          ssel_n[d] = 1'b1;
          #200;
          return;
        end
        bi = msbf[d] ? dw[d] - 1 - b : b;
        if (!cpha[d]) begin
          mosi[d] = w[bi];
          #HALF;
          sck[d]  = ~cpol[d];
          got[bi] = miso[d];
          #HALF;
          sck[d]  = cpol[d];
        end else begin
          sck[d]  = ~cpol[d];
          mosi[d] = w[bi];
          #HALF;
          sck[d]  = cpol[d];
          got[bi] = miso[d];
          #HALF;
        end
        nbit++;
      end
      if (exp_miso_q.size() > 0) check("miso_word", got, exp_miso_q.pop_front());
    end
    #HALF;
    ssel_n[d] = 1'b1;
    #200;
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 3; d++) begin
      ov_cnt[d]  = 0;
      und_cnt[d] = 0;
    end
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_miso"},        {31'h0, miso[0]},        32'd0);
    check({tag, "_miso_oe"},     {31'h0, miso_oe[0]},     32'd0);
    check({tag, "_tx_ready"},    {31'h0, tx_ready[0]},    32'd1);
    check({tag, "_rx_valid"},    {31'h0, rx_valid[0]},    32'd0);
    check({tag, "_rx_data"},     {24'h0, rx_data_a},      32'd0);
    check({tag, "_rx_overrun"},  {31'h0, rx_overrun[0]},  32'd0);
    check({tag, "_tx_underrun"}, {31'h0, tx_underrun[0]}, 32'd0);
    check({tag, "_busy"},        {31'h0, busy[0]},        32'd0);
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    sck       = 3'b010;
    ssel_n    = 3'b111;
    mosi      = 3'b000;
    tx_valid  = 3'b000;
    rx_ready  = 3'b111;
    tx_data_a = '0;
    tx_data_b = '0;
    tx_data_c = '0;
    clear_counts();
    repeat (3) @(negedge clk);
    check_reset_a("reset");
    check("reset_tx_ready_b", {31'h0, tx_ready[1]}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // 8-bit mode 0: preload 0xA5, master sends 0x3C
    tx_push(0, 32'hA5);
    @(negedge clk);
    check("t1_tx_ready_full", {31'h0, tx_ready[0]}, 32'd0);
    exp_q_a.push_back(32'h3C);
    exp_miso_q.push_back(32'hA5);
    fork
      spi_frame(0, 1, 32'h3C, 32'h0, -1);
      begin
        #100;
        check("t1_tx_ready_start", {31'h0, tx_ready[0]}, 32'd1);
        check("t1_busy",           {31'h0, busy[0]},     32'd1);
        check("t1_miso_oe",        {31'h0, miso_oe[0]},  32'd1);
      end
    join

    // 16-bit mode 3 LSB first, two words, TX words supplied while busy
    clear_counts();
    exp_q_b.push_back(32'hCAFE);
    exp_q_b.push_back(32'h0001);
    exp_miso_q.push_back(32'h1234);
    exp_miso_q.push_back(32'hBEEF);
    fork
      spi_frame(1, 2, 32'hCAFE, 32'h0001, -1);
      begin
        #20;
        tx_push(1, 32'h1234);
        tx_push(1, 32'hBEEF);
      end
    join
    check("t2_underruns", und_cnt[1], 32'd0);

    // Mode 1 with empty buffer: IDLE_WORD 0x5A on every word
    clear_counts();
    exp_q_c.push_back(32'h96);
    exp_q_c.push_back(32'h0F);
    exp_miso_q.push_back(32'h5A);
    exp_miso_q.push_back(32'h5A);
    spi_frame(2, 2, 32'h96, 32'h0F, -1);
    check("t3_underruns", und_cnt[2], 32'd2);

    // Overrun: consumer stalled across two words
    clear_counts();
    @(posedge clk);
    #1;
    rx_ready[0] = 1'b0;
    exp_q_a.push_back(32'h11);
    spi_frame(0, 2, 32'h11, 32'h22, -1);
    check("t4_overruns",     ov_cnt[0],             32'd1);
    check("t4_rx_data_kept", {24'h0, rx_data_a},    32'h11);
    check("t4_rx_valid",     {31'h0, rx_valid[0]},  32'd1);
    @(posedge clk);
    #1;
    rx_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t4_rx_valid_clr", {31'h0, rx_valid[0]}, 32'd0);

    // Partial frame of 5 bits discarded, then a full 0x81 frame
    spi_frame(0, 1, 32'hFF, 32'h0, 5);
    exp_q_a.push_back(32'h81);
    spi_frame(0, 1, 32'h81, 32'h0, -1);
    check("t5_rx_data", {24'h0, rx_data_a}, 32'h81);

    // One-cycle reset mid-frame, then a normal frame
    fork
      spi_frame(0, 1, 32'h77, 32'h0, 5);
      begin
        #300;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_a("midreset");
        rst_n = 1'b1;
      end
    join
    tx_push(0, 32'hC3);
    exp_q_a.push_back(32'h5E);
    exp_miso_q.push_back(32'hC3);
    spi_frame(0, 1, 32'h5E, 32'h0, -1);

    repeat (10) @(posedge clk);
    check("end_q_a",    exp_q_a.size(),    32'd0);
    check("end_q_b",    exp_q_b.size(),    32'd0);
    check("end_q_c",    exp_q_c.size(),    32'd0);
    check("end_q_miso", exp_miso_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
